ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, fed by the ID/EX pipeline register outputs.
//  - Executes MULT/MULTU/DIV/DIVU into the architectural HI/LO registers.
//  - Serves MFHI/MFLO/MTHI/MTLO.
//  - Raises stall to freeze IF/ID and ID/EX while an operation is in flight.

---
 rtl/mips_muldiv_defs_pkg.sv | 21 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/ex_muldiv_unit.sv | 121 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_defs_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: MIPS funct codes
// and the iterative-sequencer state encoding.
package mips_muldiv_defs;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath over {acc, quo}: shift-add for multiply,
// restoring subtract for divide. Purely combinational.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] accNext,
    output logic [WIDTH-1:0] quoNext
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
        shifted = {acc, quo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        if (isDiv) begin
            // Borrow means the trial subtract failed: keep the shifted remainder.
            accNext = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            accNext = sum[WIDTH:1];
            quoNext = {sum[0], quo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO; stalls the front end
// while a MULT*/DIV* is in flight.
module ex_muldiv_unit
    import mips_muldiv_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t state, stateNext;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi, lo, acc, quo, opnd;
    logic [WIDTH-1:0]   accNext, quoNext, absA, absB;
    logic [2*WIDTH-1:0] prod, prodNeg;
    logic               negRes, negRem, divZero, opMul;
    logic               isMul, isDiv, isSigned, isMf, isMt, accept, idleWr;

    assign isMul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    assign isDiv    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    assign isSigned = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign isMf     = (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
    assign isMt     = (funct == FUNCT_MTHI) || (funct == FUNCT_MTLO);

    assign busy   = (state != S_IDLE);
    assign idleWr = !busy && start && !flush;
    assign accept = idleWr && (isMul || isDiv);
    assign stall  = start && ((busy && (isMul || isDiv || isMf || isMt)) || accept);

    assign absA    = (isSigned && opA[WIDTH-1]) ? -opA : opA;
    assign absB    = (isSigned && opB[WIDTH-1]) ? -opB : opB;
    assign prod    = {acc, quo};
    assign prodNeg = -prod;

    always_comb begin
        result = '0;
        if (!busy && funct == FUNCT_MFHI) result = hi;
        else if (!busy && funct == FUNCT_MFLO) result = lo;
    end

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .isDiv  (state == S_DIV),
        .acc    (acc),
        .quo    (quo),
        .opnd   (opnd),
        .accNext(accNext),
        .quoNext(quoNext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:       if (accept) stateNext = isMul ? S_MUL : S_DIV;
            S_MUL, S_DIV: if (cnt == '0) stateNext = S_FIX;
            S_FIX:        stateNext = S_IDLE;
            default:      stateNext = S_IDLE;
        endcase
        if (flush) stateNext = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            acc     <= '0;
            quo     <= '0;
            opnd    <= '0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            opMul   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == S_FIX) && !flush;
            if (accept) begin
                // Multiply: quo holds multiplier, opnd multiplicand. Divide: quo holds dividend.
                acc     <= '0;
                quo     <= isMul ? absB : absA;
                opnd    <= isMul ? absA : absB;
                negRes  <= isSigned && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                negRem  <= isSigned && opA[WIDTH-1];
                divZero <= isDiv && (opB == '0);
                opMul   <= isMul;
                cnt     <= CW'(WIDTH - 1);
            end else if (state == S_MUL || state == S_DIV) begin
                acc <= accNext;
                quo <= quoNext;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end else if (state == S_FIX && !flush) begin
                if (opMul) begin
                    {hi, lo} <= negRes ? prodNeg : prod;
                end else begin
                    // Unsigned remainder of a zero divide is |opA|; re-signing restores raw opA.
                    lo <= divZero ? '1 : (negRes ? -quo : quo);
                    hi <= negRem ? -acc : acc;
                end
            end
            if (idleWr && funct == FUNCT_MTHI) hi <= opA;
            if (idleWr && funct == FUNCT_MTLO) lo <= opA;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed boundary cases plus random
// MULT/DIV traffic against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;
    import mips_muldiv_defs::*;

    logic        clk, reset, flush, start;
    logic [5:0]  funct;
    logic [31:0] opA, opB, result;
    logic        busy, stall, done;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mdlHi = 0, mdlLo = 0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .start(start), .funct(funct),
        .opA(opA), .opB(opB), .result(result), .busy(busy), .stall(stall), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdlApply(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint     sp, sq, sr;
        logic [63:0] up;
        case (f)
            FUNCT_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {mdlHi, mdlLo} = sp;
            end
            FUNCT_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {mdlHi, mdlLo} = up;
            end
            FUNCT_DIV: begin
                if (b == 0) begin mdlLo = 32'hFFFF_FFFF; mdlHi = a; end
                else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    mdlLo = sq[31:0];
                    mdlHi = sr[31:0];
                end
            end
            FUNCT_DIVU: begin
                if (b == 0) begin mdlLo = 32'hFFFF_FFFF; mdlHi = a; end
                else begin mdlLo = a / b; mdlHi = a % b; end
            end
            default: ;
        endcase
    endtask

    task automatic readHiLo(input string tag);
        @(negedge clk);
        start = 1'b1; funct = FUNCT_MFHI; #1;
        chk({tag, ".hi"}, result, mdlHi);
        chk({tag, ".mfstall"}, {31'b0, stall}, 32'd0);
        funct = FUNCT_MFLO; #1;
        chk({tag, ".lo"}, result, mdlLo);
        start = 1'b0; funct = 6'h00;
    endtask

    // Accept at one edge, then expect done in the 34th cycle counting the accept cycle.
    task automatic doOp(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        funct = f; opA = a; opB = b; start = 1'b1; #1;
        chk({tag, ".acceptStall"}, {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; funct = 6'h00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        chk({tag, ".latency"}, n, 34);
        chk({tag, ".busyAtDone"}, {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, ".donePulse"}, {31'b0, done}, 32'd0);
        mdlApply(f, a, b);
        readHiLo(tag);
    endtask

    initial begin
        logic [5:0] fTab [4];
        logic [5:0] f;
        logic [31:0] a, b;
        int n, doneCnt;
        fTab[0] = FUNCT_MULT; fTab[1] = FUNCT_MULTU; fTab[2] = FUNCT_DIV; fTab[3] = FUNCT_DIVU;

        reset = 1'b1; flush = 1'b0; start = 1'b0; funct = FUNCT_MFHI; opA = 0; opB = 0;
        #12;
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.stall", {31'b0, stall}, 32'd0);
        chk("rst.result", result, 32'd0);
        @(negedge clk); reset = 1'b0; funct = 6'h00;

        doOp("multuMax", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multuMax.hiConst", mdlHi, 32'hFFFF_FFFE);
        doOp("mult-7x3", FUNCT_MULT, -32'sd7, 32'd3);
        doOp("div-7/2", FUNCT_DIV, -32'sd7, 32'd2);
        doOp("divu100/0", FUNCT_DIVU, 32'd100, 32'd0);
        doOp("divOvf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        doOp("multMin", FUNCT_MULT, 32'h8000_0000, 32'h8000_0000);
        doOp("divNeg/0", FUNCT_DIV, -32'sd55, 32'd0);

        for (int i = 0; i < 10; i++) begin
            f = fTab[$urandom_range(0, 3)];
            a = $urandom;
            b = (i % 5 == 4) ? 32'd0 : ((i % 2 == 1) ? $urandom : $urandom_range(1, 1000));
            if (i % 3 == 0) b = -b;
            doOp($sformatf("rnd%0d", i), f, a, b);
        end

        // Unrelated funct: ignored, no stall.
        @(negedge clk); funct = 6'h20; start = 1'b1; #1;
        chk("otherFunct.stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("otherFunct.busy", {31'b0, busy}, 32'd0);
        start = 1'b0;

        // MFLO while a DIV is in flight.
        @(negedge clk); funct = FUNCT_DIV; opA = 32'd1000; opB = -32'sd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; funct = 6'h00;
        repeat (5) @(negedge clk);
        funct = FUNCT_MFLO; start = 1'b1; #1;
        mdlApply(FUNCT_DIV, 32'd1000, -32'sd7);
        n = 0;
        while (busy && n < 60) begin
            chk("mfloWait.stall", {31'b0, stall}, 32'd1);
            chk("mfloWait.result", result, 32'd0);
            @(negedge clk); #1;
            n++;
        end
        chk("mfloWait.busyFell", {31'b0, busy}, 32'd0);
        chk("mfloWait.stallDrop", {31'b0, stall}, 32'd0);
        chk("mfloWait.lo", result, mdlLo);
        start = 1'b0; funct = 6'h00;
        @(negedge clk);

        // MTHI then MFHI.
        @(negedge clk); funct = FUNCT_MTHI; opA = 32'h1234; start = 1'b1; #1;
        chk("mthi.stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        mdlHi = 32'h1234;
        chk("mthi.busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("mthi.noDone", {31'b0, done}, 32'd0);
        funct = FUNCT_MFHI; #1;
        chk("mfhi.result", result, 32'h1234);
        chk("mfhi.stall", {31'b0, stall}, 32'd0);
        start = 1'b0;

        // Flush coincident with an IDLE MULT: flush wins.
        @(negedge clk); funct = FUNCT_MULT; opA = 5; opB = 6; start = 1'b1; flush = 1'b1; #1;
        chk("flushStart.stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("flushStart.busy", {31'b0, busy}, 32'd0);
        start = 1'b0; flush = 1'b0;

        // Flush at iteration 10 of a MULT.
        @(negedge clk); funct = FUNCT_MULT; opA = 32'd77; opB = 32'd99; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; funct = 6'h00;
        repeat (10) @(negedge clk);
        chk("flushMid.busyBefore", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flushMid.busy", {31'b0, busy}, 32'd0);
        doneCnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        chk("flushMid.noDone", doneCnt, 0);
        readHiLo("flushMid");

        // Asynchronous reset between edges of an in-flight DIV.
        @(negedge clk); funct = FUNCT_DIV; opA = 32'd12345; opB = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        reset = 1'b1; funct = FUNCT_DIV; start = 1'b1; #1;
        chk("rstMid.busy", {31'b0, busy}, 32'd0);
        funct = FUNCT_MFHI; #1;
        chk("rstMid.hi", result, 32'd0);
        funct = FUNCT_MFLO; #1;
        chk("rstMid.lo", result, 32'd0);
        funct = FUNCT_DIV;
        @(posedge clk); #1;
        chk("rstMid.startIgnored", {31'b0, busy}, 32'd0);
        @(negedge clk); reset = 1'b0; start = 1'b0; funct = 6'h00;
        mdlHi = 0; mdlLo = 0;
        readHiLo("afterRst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
